// File: rtl/stopwatch_lap_fifo_pkg.sv
// Shared stopwatch definitions: counter width, terminal value, time type and
// the modulo-(MAX+1) split helper used by anything downstream of the counter.
package stopwatch_pkg;

    localparam int SW_DATA_WIDTH = 16;
    localparam int SW_MAX        = 99;

    typedef logic [SW_DATA_WIDTH-1:0] sw_time_t;

    // One extra bit keeps count + (MAX+1) from overflowing before the subtraction.
    function automatic sw_time_t sw_delta(input sw_time_t now, input sw_time_t prev);
        logic [SW_DATA_WIDTH:0] wide;
        if (now >= prev) begin
            wide = {1'b0, now} - {1'b0, prev};
        end else begin
            wide = {1'b0, now} + (SW_DATA_WIDTH + 1)'(SW_MAX + 1) - {1'b0, prev};
        end
        return sw_time_t'(wide);
    endfunction

endpackage

// File: rtl/stopwatch_lap_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a separate occupancy counter,
// so full and empty stay unambiguous when the pointers meet.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     push_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_done;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign valid = !empty;

    // A pop in the same cycle frees the slot, so a push is accepted even when full.
    assign pop_done  = pop && !empty && !clear;
    assign push_done = push && (!full || pop_done) && !clear;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_done) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_done) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_done) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_done, pop_done})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_lap_fifo.sv
// Lap capture stage: samples the stopwatch count on each lap pulse and queues
// records. Define STOPWATCH_LAP_DELTA_EN to store split times instead of absolute.
module stopwatch_lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int DATA_WIDTH = SW_DATA_WIDTH,
    parameter int MAX        = SW_MAX,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     lap,
    input  logic [DATA_WIDTH-1:0]    count,
    output logic                     lap_valid,
    input  logic                     lap_ready,
    output logic [DATA_WIDTH-1:0]    lap_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    logic [DATA_WIDTH-1:0] record;
    logic                  push_done;
    logic                  drop;

`ifdef STOPWATCH_LAP_DELTA_EN
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH:0]   wide;

    // Split is taken modulo the counter wrap; multiple wraps cannot be seen.
    always_comb begin
        wide = '0;
        if (count >= prev) begin
            wide = {1'b0, count} - {1'b0, prev};
        end else begin
            wide = {1'b0, count} + (DATA_WIDTH + 1)'(MAX + 1) - {1'b0, prev};
        end
    end

    assign record = DATA_WIDTH'(wide);

    // Dropped laps leave the reference alone so the next split spans back to the last kept lap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else if (clear) begin
            prev <= '0;
        end else if (push_done) begin
            prev <= count;
        end
    end
`else
    assign record = count;
`endif

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (lap),
        .pop       (lap_ready),
        .wr_data   (record),
        .rd_data   (lap_data),
        .valid     (lap_valid),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .push_done (push_done)
    );

    assign drop = lap && !clear && !push_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

endmodule
